// File: rtl/cpu_defs.sv
// Shared definitions for the CPU memory host: word/address widths,
// instruction opcodes (bits [15:11]) and the host FSM state encoding.
package cpu_defs;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 8;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OP_W-1:0] OP_HALT  = 5'b00001;
  localparam logic [OP_W-1:0] OP_LOAD  = 5'b00010;
  localparam logic [OP_W-1:0] OP_STORE = 5'b00011;
  localparam logic [OP_W-1:0] OP_ADD   = 5'b01000;
  localparam logic [OP_W-1:0] OP_CMP   = 5'b01001;
  localparam logic [OP_W-1:0] OP_BZ    = 5'b01010;
  localparam logic [OP_W-1:0] OP_BN    = 5'b01011;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

endpackage

// File: rtl/cpu_sync_ram.sv
// Single-clock RAM, one write port and one read port. rd_data is the
// registered read (read-before-write on an address collision); rd_next is
// the word that rd_data will take at the coming edge, used for look-ahead
// decode by the host.
module cpu_sync_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] rd_next
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  assign rd_next = mem[rd_addr];

  // write and registered read share the edge, so a colliding read sees the old word
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cpu_mem_host.sv
// Memory-side host for CPU_top: instruction and data RAMs, a streaming
// loader that fills them in IDLE, and the run sequencer that starts the CPU
// and stops it when a HALT word is fetched.
//
//   state   | meaning
//   IDLE    | loader owns both RAMs, CPU held off
//   START   | one-cycle start pulse to the CPU, run counter cleared
//   RUN     | CPU owns the RAMs, cycles counted
//   HALTED  | HALT fetched, done high, wait for ld_clr
module cpu_mem_host
  import cpu_defs::*;
#(
  parameter int              AW      = ADDR_W,
  parameter int              DW      = WORD_W,
  parameter logic [OP_W-1:0] HALT_OP = OP_HALT,
  parameter int              CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    i_addr,
  output logic [DW-1:0]    i_datain,
  input  logic [AW-1:0]    d_addr,
  input  logic             d_we,
  input  logic [DW-1:0]    d_dataout,
  output logic [DW-1:0]    d_datain,
  output logic             enable,
  output logic             start,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             ld_sel,
  input  logic [DW-1:0]    ld_data,
  input  logic             ld_go,
  input  logic             ld_clr,
  output logic             done,
  output logic             ld_ovf,
  output logic [CNT_W-1:0] run_cycles
);

  localparam logic [DW-1:0] OP_MASK   = {{OP_W{1'b1}}, {(DW-OP_W){1'b0}}};
  localparam logic [DW-1:0] HALT_WORD = {HALT_OP, {(DW-OP_W){1'b0}}};

  logic [1:0]    state, state_nx;
  logic [AW-1:0] ptr_i, ptr_d;
  logic          cpu_view;
  logic          in_idle, in_run, in_halted;
  logic          ld_xfer, halt_hit;
  logic          iram_we, dram_we;
  logic [AW-1:0] dram_waddr;
  logic [DW-1:0] dram_wdata;
  logic [DW-1:0] iram_q, iram_next, dram_q, dram_next_unused;

  assign in_idle   = (state == ST_IDLE);
  assign in_run    = (state == ST_RUN);
  assign in_halted = (state == ST_HALTED);

  assign ld_ready = reset & in_idle;
  assign start    = (state == ST_START);
  assign enable   = (state == ST_START) | in_run;
  assign done     = in_halted;

  // ld_go wins over a same-cycle loader word, which is dropped
  assign ld_xfer  = in_idle & ld_valid & ~ld_go;
  assign halt_hit = ((iram_next & OP_MASK) == HALT_WORD);

  assign iram_we    = ld_xfer & ~ld_sel;
  assign dram_we    = in_run ? d_we      : (ld_xfer & ld_sel);
  assign dram_waddr = in_run ? d_addr    : ptr_d;
  assign dram_wdata = in_run ? d_dataout : ld_data;

  // RAM outputs reach the CPU only for words registered during RUN
  assign i_datain = cpu_view ? iram_q : '0;
  assign d_datain = cpu_view ? dram_q : '0;

  cpu_sync_ram #(.AW(AW), .DW(DW)) u_iram (
    .clock   (clock),
    .wr_en   (iram_we),
    .wr_addr (ptr_i),
    .wr_data (ld_data),
    .rd_addr (i_addr),
    .rd_data (iram_q),
    .rd_next (iram_next)
  );

  cpu_sync_ram #(.AW(AW), .DW(DW)) u_dram (
    .clock   (clock),
    .wr_en   (dram_we),
    .wr_addr (dram_waddr),
    .wr_data (dram_wdata),
    .rd_addr (d_addr),
    .rd_data (dram_q),
    .rd_next (dram_next_unused)
  );

  // next-state decode; HALT is seen on the word about to be registered
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (ld_go)    state_nx = ST_START;
      ST_START:                state_nx = ST_RUN;
      ST_RUN:    if (halt_hit) state_nx = ST_HALTED;
      ST_HALTED: if (ld_clr)   state_nx = ST_IDLE;
      default:                 state_nx = ST_IDLE;
    endcase
  end

  // state register and CPU-view flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cpu_view <= 1'b0;
    end else begin
      state    <= state_nx;
      cpu_view <= in_run;
    end
  end

  // load pointers and sticky wrap flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_i  <= '0;
      ptr_d  <= '0;
      ld_ovf <= 1'b0;
    end else if (in_halted && ld_clr) begin
      ptr_i <= '0;
      ptr_d <= '0;
    end else if (ld_xfer) begin
      if (ld_sel) begin
        ptr_d <= ptr_d + 1'b1;
        if (&ptr_d) ld_ovf <= 1'b1;
      end else begin
        ptr_i <= ptr_i + 1'b1;
        if (&ptr_i) ld_ovf <= 1'b1;
      end
    end
  end

  // saturating RUN-cycle counter, cleared on the way into START
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_cycles <= '0;
    end else if (in_idle && ld_go) begin
      run_cycles <= '0;
    end else if (in_run && !(&run_cycles)) begin
      run_cycles <= run_cycles + 1'b1;
    end
  end

endmodule
